// File: rtl/multdiv_pkg.sv
// Shared constants and types for the iterative multiply/divide sequencer.
package multdiv_pkg;

    // Instruction fields that identify MUL and DIV in the DX stage
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    // One engine iteration per operand bit
    localparam int ITERATIONS = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

endpackage

// File: rtl/multdiv_datapath.sv
// Shift-add / restoring shift-subtract engine with sign fix-up at finish.
// Operands are held as unsigned magnitudes; the sign is reapplied once the
// magnitude result is complete. The most negative value has magnitude
// 2^(WIDTH-1), which still fits an unsigned WIDTH-bit register, and the
// add/subtract is WIDTH+1 bits so carries and borrows are never lost.
module multdiv_datapath
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  mode_e            mode,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             exception
);

    // acc: MUL -> partial product; DIV -> remainder:quotient
    logic [2*WIDTH-1:0] acc;
    // opa: MUL multiplier (shifts right) / DIV dividend (shifts left)
    logic [WIDTH-1:0]   opa;
    // opb: MUL multiplicand / DIV divisor
    logic [WIDTH-1:0]   opb;
    logic               sign;

    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               geq;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mag;
    logic [2*WIDTH-1:0] sgn_full;
    logic               ovf;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Operand magnitudes for capture at start
    always_comb begin
        mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
        mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;
    end

    // One iteration of the active algorithm, plus the signed final value
    // derived from the post-iteration accumulator (used on the last step)
    always_comb begin
        addend = opa[0] ? {1'b0, opb} : '0;
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
        rem_sh = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
        diff   = rem_sh - {1'b0, opb};
        geq    = ~diff[WIDTH];
        if (mode == MODE_DIV)
            acc_next = {(geq ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                        acc[WIDTH-2:0], geq};
        else
            acc_next = {sum, acc[WIDTH-1:1]};
        mag      = (mode == MODE_DIV) ? {{WIDTH{1'b0}}, acc_next[WIDTH-1:0]} : acc_next;
        sgn_full = (sign && (|mag)) ? (~mag + 1'b1) : mag;
        // Product fits WIDTH bits only if the upper bits are pure sign extension
        ovf      = ~((&sgn_full[2*WIDTH-1:WIDTH-1]) | ~(|sgn_full[2*WIDTH-1:WIDTH-1]));
    end

    // Operand capture, iteration and result registration
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            opa       <= '0;
            opb       <= '0;
            sign      <= 1'b0;
            result    <= '0;
            exception <= 1'b0;
        end else begin
            if (load) begin
                acc  <= '0;
                opa  <= mag_a;
                opb  <= mag_b;
                sign <= a[WIDTH-1] ^ b[WIDTH-1];
            end else if (step) begin
                acc <= acc_next;
                opa <= (mode == MODE_DIV) ? (opa << 1) : (opa >> 1);
            end
            if (finish) begin
                if (mode == MODE_MUL) begin
                    result    <= sgn_full[WIDTH-1:0];
                    exception <= ovf;
                end else if (opb == '0) begin
                    // Divide by zero: the engine still ran, the quotient is discarded
                    result    <= '0;
                    exception <= 1'b1;
                end else begin
                    result    <= sgn_full[WIDTH-1:0];
                    exception <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Detects MUL/DIV in DX, stalls the pipeline for the 32-iteration run and
// presents result, exception and the captured instruction for one cycle.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      dx_ir,
    input  logic [WIDTH-1:0] dx_a,
    input  logic [WIDTH-1:0] dx_b,
    output logic             pw_stall,
    output logic [31:0]      pw_ir,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_valid
);

    state_e     state;
    state_e     state_nxt;
    logic [5:0] cnt;
    logic       start_mul;
    logic       start_div;
    logic       load;
    logic       step;
    logic       finish;
    mode_e      mode;

    // Instruction decode; only consulted in IDLE and DONE
    always_comb begin
        start_mul = (dx_ir[31:27] == OP_RTYPE) && (dx_ir[6:2] == ALU_MUL);
        start_div = (dx_ir[31:27] == OP_RTYPE) && (dx_ir[6:2] == ALU_DIV);
    end

    // Next-state and engine control decode
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_mul) begin
                    state_nxt = S_MUL;
                    load      = 1'b1;
                end else if (start_div) begin
                    state_nxt = S_DIV;
                    load      = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                step = 1'b1;
                if (cnt == 6'(ITERATIONS - 1)) begin
                    state_nxt = S_DONE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mode = (state == S_DIV) ? MODE_DIV : MODE_MUL;

    // State, iteration counter and captured instruction
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            pw_ir <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt   <= '0;
                pw_ir <= dx_ir;
            end else if (step) begin
                cnt <= cnt + 6'd1;
            end
        end
    end

    // Status outputs decode straight from the state register
    assign pw_stall     = (state == S_MUL) || (state == S_DIV);
    assign result_valid = (state == S_DONE);

    multdiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock     (clock),
        .reset     (reset),
        .mode      (mode),
        .load      (load),
        .step      (step),
        .finish    (finish),
        .a         (dx_a),
        .b         (dx_b),
        .result    (result),
        .exception (exception)
    );

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer against an arithmetic reference.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dx_ir = 32'h0;
    logic [31:0] dx_a  = 32'h0;
    logic [31:0] dx_b  = 32'h0;
    logic        pw_stall;
    logic [31:0] pw_ir;
    logic [31:0] result;
    logic        exception;
    logic        result_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [31:0] NOP = 32'h0000_0010;

    multdiv_sequencer #(.WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .dx_ir        (dx_ir),
        .dx_a         (dx_a),
        .dx_b         (dx_b),
        .pw_stall     (pw_stall),
        .pw_ir        (pw_ir),
        .result       (result),
        .exception    (exception),
        .result_valid (result_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_ir(input bit is_div);
        logic [31:0] ir;
        ir        = $urandom;
        ir[31:27] = 5'b00000;
        ir[6:2]   = is_div ? 5'b00111 : 5'b00110;
        return ir;
    endfunction

    // Reference: signed 64-bit product / truncating signed quotient
    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        logic signed [63:0] p;
        logic signed [31:0] sa, sb, q;
        sa = a;
        sb = b;
        if (!is_div) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'h0) begin
            r = 32'h0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b0;
        end else begin
            q = sa / sb;
            r = q;
            e = 1'b0;
        end
    endfunction

    task automatic issue(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        dx_ir = ir;
        dx_a  = a;
        dx_b  = b;
    endtask

    // Follows a run started at the previous edge; c counts cycles after issue.
    // In cycle 1 DX is replaced by hold_*; when the result appears, next_* is
    // presented so it can start back-to-back.
    task automatic collect(input logic [31:0] hold_ir, input logic [31:0] hold_a, input logic [31:0] hold_b,
                           input logic [31:0] next_ir, input logic [31:0] next_a, input logic [31:0] next_b,
                           output int lat, output int nstall, output logic stall_done,
                           output logic [31:0] r, output logic e, output logic [31:0] pir);
        lat = -1; nstall = 0; stall_done = 1'bx; r = 'x; e = 1'bx; pir = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (c == 1) begin
                dx_ir = hold_ir; dx_a = hold_a; dx_b = hold_b;
            end
            if (result_valid) begin
                lat = c; r = result; e = exception; pir = pw_ir; stall_done = pw_stall;
                dx_ir = next_ir; dx_a = next_a; dx_b = next_b;
                break;
            end
            if (pw_stall) nstall++;
        end
    endtask

    task automatic test_reset();
        dx_ir = mk_ir(0); dx_a = 32'd3; dx_b = 32'd5;
        repeat (3) @(negedge clock);
        total_cnt++;
        if ({pw_stall, result_valid, exception, result, pw_ir} !== 67'h0)
            $display("FAIL reset_outputs stall=%b valid=%b exc=%b result=%h pw_ir=%h expected all 0",
                     pw_stall, result_valid, exception, result, pw_ir);
        else pass_cnt++;
        // Near-miss encodings must not start the engine
        dx_ir = 32'h0800_0018;   // opcode 00001 with ALU_MUL field
        reset = 1'b1;
        begin
            int busy = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                if (i == 1) dx_ir = 32'h0000_0014;   // opcode 0, ALU field 00101
                if (pw_stall || result_valid) busy++;
            end
            total_cnt++;
            if (busy !== 0) $display("FAIL no_start_decode busy_cycles=%0d expected 0", busy);
            else pass_cnt++;
        end
        dx_ir = NOP;
    endtask

    task automatic test_mul();
        logic [31:0] ir, r, pir; logic e, sd; int lat, ns;
        ir = mk_ir(0);
        issue(ir, 32'd7, 32'hFFFF_FFFA);
        collect(NOP, 0, 0, NOP, 0, 0, lat, ns, sd, r, e, pir);
        total_cnt++; if (lat !== 33) $display("FAIL mul_latency got %0d expected 33", lat); else pass_cnt++;
        total_cnt++; if (ns !== 32) $display("FAIL mul_stall_cycles got %0d expected 32", ns); else pass_cnt++;
        total_cnt++; if (sd !== 1'b0) $display("FAIL mul_stall_in_done got %b expected 0", sd); else pass_cnt++;
        total_cnt++; if (r !== 32'hFFFF_FFD6) $display("FAIL mul_result got %h expected ffffffd6", r); else pass_cnt++;
        total_cnt++; if (e !== 1'b0) $display("FAIL mul_exception got %b expected 0", e); else pass_cnt++;
        total_cnt++; if (pir !== ir) $display("FAIL mul_pw_ir got %h expected %h", pir, ir); else pass_cnt++;
    endtask

    task automatic test_mul_overflow();
        logic [31:0] r, pir; logic e, sd; int lat, ns;
        issue(mk_ir(0), 32'h0001_0000, 32'h0001_0000);
        collect(NOP, 0, 0, NOP, 0, 0, lat, ns, sd, r, e, pir);
        total_cnt++;
        if (lat !== 33 || r !== 32'h0 || e !== 1'b1)
            $display("FAIL mul_ovf lat=%0d result=%h exc=%b expected 33/00000000/1", lat, r, e);
        else pass_cnt++;
        issue(mk_ir(0), 32'h8000_0000, 32'd1);
        collect(NOP, 0, 0, NOP, 0, 0, lat, ns, sd, r, e, pir);
        total_cnt++;
        if (lat !== 33 || r !== 32'h8000_0000 || e !== 1'b0)
            $display("FAIL mul_minint lat=%0d result=%h exc=%b expected 33/80000000/0", lat, r, e);
        else pass_cnt++;
    endtask

    task automatic test_div();
        logic [31:0] r, pir; logic e, sd; int lat, ns;
        issue(mk_ir(1), 32'hFFFF_FFEF, 32'd5);
        collect(NOP, 0, 0, NOP, 0, 0, lat, ns, sd, r, e, pir);
        total_cnt++;
        if (lat !== 33 || r !== 32'hFFFF_FFFD || e !== 1'b0)
            $display("FAIL div_neg lat=%0d result=%h exc=%b expected 33/fffffffd/0", lat, r, e);
        else pass_cnt++;
        issue(mk_ir(1), 32'h8000_0000, 32'hFFFF_FFFF);
        collect(NOP, 0, 0, NOP, 0, 0, lat, ns, sd, r, e, pir);
        total_cnt++;
        if (lat !== 33 || r !== 32'h8000_0000 || e !== 1'b0)
            $display("FAIL div_minint lat=%0d result=%h exc=%b expected 33/80000000/0", lat, r, e);
        else pass_cnt++;
    endtask

    task automatic test_div_zero();
        logic [31:0] r, pir; logic e, sd; int lat, ns;
        issue(mk_ir(1), 32'd9, 32'd0);
        collect(NOP, 0, 0, NOP, 0, 0, lat, ns, sd, r, e, pir);
        total_cnt++; if (ns !== 32 || lat !== 33) $display("FAIL div0_timing stall=%0d lat=%0d expected 32/33", ns, lat); else pass_cnt++;
        total_cnt++; if (r !== 32'h0 || e !== 1'b1) $display("FAIL div0_result result=%h exc=%b expected 00000000/1", r, e); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ir2, r, pir; logic e, sd; int lat, ns;
        ir2 = mk_ir(1);
        issue(mk_ir(0), 32'd3, 32'd4);
        // A different MUL sits in DX for the whole run; it must not restart
        collect(mk_ir(0), 32'd5, 32'd5, ir2, 32'd100, 32'd7, lat, ns, sd, r, e, pir);
        total_cnt++;
        if (lat !== 33 || ns !== 32 || sd !== 1'b0 || r !== 32'd12)
            $display("FAIL b2b_first lat=%0d stall=%0d stall_done=%b result=%h expected 33/32/0/0000000c", lat, ns, sd, r);
        else pass_cnt++;
        collect(NOP, 0, 0, NOP, 0, 0, lat, ns, sd, r, e, pir);
        total_cnt++;
        if (lat !== 33 || ns !== 32 || r !== 32'd14 || e !== 1'b0)
            $display("FAIL b2b_second lat=%0d stall=%0d result=%h exc=%b expected 33/32/0000000e/0", lat, ns, r, e);
        else pass_cnt++;
        total_cnt++; if (pir !== ir2) $display("FAIL b2b_pw_ir got %h expected %h", pir, ir2); else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        logic [31:0] r, pir; logic e, sd; int lat, ns, pulses;
        issue(mk_ir(0), 32'd1234, 32'd5678);
        @(negedge clock);
        dx_ir = NOP;
        repeat (9) @(negedge clock);    // now in cycle 10
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({pw_stall, result_valid, exception, result, pw_ir} !== 67'h0)
            $display("FAIL midrun_reset_outputs stall=%b valid=%b exc=%b result=%h pw_ir=%h expected all 0",
                     pw_stall, result_valid, exception, result, pw_ir);
        else pass_cnt++;
        pulses = 0;
        repeat (3) begin
            @(negedge clock);
            if (result_valid || pw_stall) pulses++;
        end
        total_cnt++; if (pulses !== 0) $display("FAIL midrun_no_pulse got %0d active cycles expected 0", pulses); else pass_cnt++;
        reset = 1'b1;
        dx_ir = mk_ir(1); dx_a = 32'd8; dx_b = 32'd2;
        collect(NOP, 0, 0, NOP, 0, 0, lat, ns, sd, r, e, pir);
        total_cnt++;
        if (lat !== 33 || r !== 32'd4 || e !== 1'b0)
            $display("FAIL post_reset_div lat=%0d result=%h exc=%b expected 33/00000004/0", lat, r, e);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] a, b, ir, r, pir, er; logic e, ee, sd; int lat, ns; bit is_div;
        for (int i = 0; i < 24; i++) begin
            is_div = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                2: a = $urandom_range(0, 1) ? -$urandom_range(0, 1000) : $urandom_range(0, 1000);
                3: a = $urandom_range(0, 65535);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(0, 1) ? -$urandom_range(1, 100) : $urandom_range(1, 100);
                3: b = $urandom_range(0, 65535);
                default: b = $urandom;
            endcase
            ir = mk_ir(is_div);
            model(is_div, a, b, er, ee);
            issue(ir, a, b);
            collect(NOP, 0, 0, NOP, 0, 0, lat, ns, sd, r, e, pir);
            total_cnt++;
            if (lat !== 33 || ns !== 32) $display("FAIL rand_timing[%0d] lat=%0d stall=%0d expected 33/32", i, lat, ns);
            else pass_cnt++;
            total_cnt++;
            if (r !== er || e !== ee)
                $display("FAIL rand_result[%0d] %s a=%h b=%h got %h/%b expected %h/%b",
                         i, is_div ? "div" : "mul", a, b, r, e, er, ee);
            else pass_cnt++;
            total_cnt++; if (pir !== ir) $display("FAIL rand_pw_ir[%0d] got %h expected %h", i, pir, ir); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_overflow();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Sequencing controller for the processor's iterative multiply/divide resource. It detects a MUL or DIV instruction in the DX stage, captures its operands and instruction word, and runs a 32-iteration shift-add or shift-subtract engine. It drives `pw_stall` into the pipeline stall logic for the whole run, then presents result, exception flag and the captured instruction to the PW/writeback path for one cycle.

## Interface
- `WIDTH`, 32: operand/result width; only 32 is supported. Iteration count equals `WIDTH`.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `dx_ir` in 32: instruction word currently in DX.
- `dx_a` in 32: DX operand A (rs, post-bypass).
- `dx_b` in 32: DX operand B (rt, post-bypass).
- `pw_stall` out 1: high while the engine is busy; ORed into the pipeline stall.
- `pw_ir` out 32: captured MUL/DIV instruction, giving `rd` to writeback.
- `result` out 32: signed result; valid only with `result_valid`.
- `exception` out 1: overflow or divide-by-zero; valid only with `result_valid`.
- `result_valid` out 1: one-cycle pulse when the result is ready.

## Operation
- Decode:
  - start_mul = `dx_ir[31:27]==5'b00000 && dx_ir[6:2]==5'b00110`
  - start_div = `dx_ir[31:27]==5'b00000 && dx_ir[6:2]==5'b00111`
- States:
  - IDLE: start_mul → MUL; start_div → DIV; otherwise stay.
  - MUL: counter reaches 31 → DONE.
  - DIV: counter reaches 31 → DONE.
  - DONE: start_mul → MUL; start_div → DIV; otherwise → IDLE.
- Start decode is evaluated only in IDLE and DONE. In MUL/DIV, `dx_ir` is frozen by the stall and is ignored.
- On start:
  - Latch `dx_ir` into `pw_ir`.
  - Latch |a| and |b|; record sign = a[31]^b[31].
  - Clear the 6-bit counter and the 64-bit accumulator/remainder.
- MUL, per iteration: if multiplier bit 0 is set, add the multiplicand into the upper accumulator half; then shift right by 1.
- DIV, per iteration (restoring): shift remainder:quotient left by 1; if remainder ≥ |b|, subtract and set quotient bit 0.
- Final sign: apply two's-complement negation on entry to DONE when sign=1 and the magnitude result is nonzero.
- MUL result and exception:
  - `result` = low 32 bits of the signed 64-bit product.
  - `exception`=1 when product bits [63:31] are not all equal.
- DIV result and exception:
  - Quotient truncates toward zero; the remainder is discarded.
  - b==0: `result`=0 and `exception`=1; the full 32 cycles still run.
  - 0x80000000 / −1: `result`=0x80000000, `exception`=0.
- Magnitude of 0x80000000 is taken as unsigned 0x80000000 (33-bit internal path).

## Timing
- Cycle 0: MUL/DIV is in DX, `pw_stall`=0. The start is captured at the cycle-0 → 1 edge.
- Cycles 1–32 (MUL/DIV states): `pw_stall`=1, `result_valid`=0.
- Cycle 33 (DONE): `pw_stall`=0 and `result_valid`=1. `result`, `exception` and `pw_ir` are registered and stable for this cycle.
- Latency from DX to result is 33 cycles.
- Back-to-back: a MUL/DIV in DX during DONE starts at the next edge. `pw_stall` then rises in cycle 34 with no idle gap.
- `pw_stall` is a registered, state-decoded output with no combinational path from `dx_ir`.
- Reset values: state=IDLE, all outputs 0, `pw_ir`=0.
- Reset asserted mid-run aborts immediately with no result pulse. The first edge after deassertion samples `dx_ir` as in IDLE.
- Outside DONE, `result`, `exception` and `pw_ir` hold their last values but are don't-care.

## Structure
- Shared package `multdiv_pkg`:
  - Opcode constant `OP_RTYPE`=5'b00000.
  - ALU-op constants `ALU_MUL`=5'b00110 and `ALU_DIV`=5'b00111.
  - State encoding IDLE/MUL/DIV/DONE.
  - `ITERATIONS`=32.
- One sub-module, `multdiv_datapath`, holds the 64-bit accumulator, the 33-bit add/subtract and the shift logic. It takes `mode`/`load`/`step`/`finish` controls from the FSM in `multdiv_sequencer`.

## Test plan
- MUL: a=7, b=−6 → `pw_stall` high exactly in cycles 1–32; cycle 33 `result`=0xFFFFFFD6 (−42), `exception`=0, `pw_ir` equals the issued instruction.
- MUL overflow: 0x00010000 × 0x00010000 → `result`=0x00000000, `exception`=1. Also 0x80000000 × 1 → 0x80000000, `exception`=0.
- DIV: −17 / 5 → `result`=0xFFFFFFFD (−3), `exception`=0. Also 0x80000000 / −1 → 0x80000000, `exception`=0.
- DIV by zero: 9 / 0 → `pw_stall` for 32 cycles, then `result`=0, `exception`=1.
- Back-to-back: MUL 3×4 then DIV 100/7 presented in the DONE cycle → results 12 at cycle 33 and 14 at cycle 66; `pw_stall` low only in cycle 33. A MUL in DX during cycles 1–32 is not restarted.
- Reset: assert `reset` low at cycle 10 of a MUL → all outputs 0 immediately, no `result_valid`. After release, a new DIV 8/2 returns 4 after 33 cycles.
